// File: rtl/sfm_pkg.sv
// Shared types for the softmax output packer: element formats,
// FSM states and the registered status flags bundle.
package sfm_pkg;

    typedef enum logic [2:0] {
        FP32,
        FP64,
        FP16,
        FP8,
        FP16ALT
    } fp_format_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        unique case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 16;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sfm_state_e;

    localparam int unsigned SFM_CNT_W = 32;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic [SFM_CNT_W-1:0] cnt;
    } sfm_flags_t;

endpackage

// File: rtl/sfm_packer_fifo.sv
// First-word-fall-through FIFO with circular pointers; the head entry
// is presented on data_o whenever the FIFO is non-empty.
module sfm_packer_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  last_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_cnt;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_cnt == CNT_W'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign last_o  = (r_cnt == CNT_W'(1));
    assign data_o  = r_mem[r_rptr];

    // a push into a full FIFO or a pop from an empty one is dropped
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // storage, pointer and occupancy update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sfm_out_packer.sv
// Packs datapath result vectors into output stream beats with byte
// strobes, buffering through a small FIFO under a len-bounded job FSM.
module sfm_out_packer
    import sfm_pkg::*;
#(
    parameter fp_format_e  FPFORMAT   = FP16ALT,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned WIDTH      = fp_width(FPFORMAT),
    parameter int unsigned VECT_WIDTH = (DATA_WIDTH - 32) / WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DATA_WIDTH-33:0]  data_i,
    input  logic [VECT_WIDTH-1:0]   strb_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [LEN_WIDTH-1:0]    cnt_o
);

    localparam int unsigned PAY_W  = DATA_WIDTH - 32;
    localparam int unsigned LANE_B = WIDTH / 8;
    localparam int unsigned FIFO_W = VECT_WIDTH + PAY_W;

    sfm_state_e           r_state;
    sfm_flags_t           r_flags;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_acc;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic [LEN_WIDTH-1:0]  w_acc_nxt;
    logic [FIFO_W-1:0]     w_rd;
    logic [VECT_WIDTH-1:0] w_strb;
    logic [PAY_W-1:0]      w_pay;

    assign ready_o   = (r_state == RUN) && !w_full;
    assign valid_o   = !w_empty;
    assign w_push    = valid_i && ready_o;
    assign w_pop     = valid_o && ready_i;
    assign w_acc_nxt = r_acc + 1'b1;

    assign busy_o = r_flags.busy;
    assign done_o = r_flags.done;
    assign cnt_o  = r_flags.cnt[LEN_WIDTH-1:0];

    sfm_packer_fifo #(
        .DATA_WIDTH(FIFO_W),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .push_i (w_push),
        .data_i ({strb_i, data_i}),
        .pop_i  (w_pop),
        .data_o (w_rd),
        .full_o (w_full),
        .empty_o(w_empty),
        .last_o (w_last)
    );

    assign w_strb = w_rd[FIFO_W-1 -: VECT_WIDTH];
    assign w_pay  = w_rd[PAY_W-1:0];

    // expand element strobes to bytes and zero disabled lanes
    always_comb begin
        data_o = '0;
        strb_o = '0;
        for (int i = 0; i < VECT_WIDTH; i++) begin
            if (w_strb[i]) begin
                data_o[WIDTH*i +: WIDTH] = w_pay[WIDTH*i +: WIDTH];
            end
            strb_o[LANE_B*i +: LANE_B] = {LANE_B{w_strb[i]}};
        end
    end

    // job FSM with registered busy/done flags and output beat counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_flags <= '0;
            r_len   <= '0;
            r_acc   <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_flags <= '0;
            r_len   <= '0;
            r_acc   <= '0;
        end else begin
            r_flags.done <= 1'b0;
            if (w_pop) begin
                r_flags.cnt <= r_flags.cnt + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_len       <= len_i;
                        r_acc       <= '0;
                        r_flags.cnt <= '0;
                        if (len_i == '0) begin
                            r_state      <= DONE;
                            r_flags.done <= 1'b1;
                        end else begin
                            r_state      <= RUN;
                            r_flags.busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_acc <= w_acc_nxt;
                        if (w_acc_nxt == r_len) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state      <= DONE;
                        r_flags.busy <= 1'b0;
                        r_flags.done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfm_out_packer.sv
// Self-checking bench for sfm_out_packer: table-driven jobs with a
// beat scoreboard, plus hand-written stall, clear, len0 and reset cases.
module tb_sfm_out_packer;
    import sfm_pkg::*;

    localparam int DW = 128;
    localparam int LW = 16;
    localparam int VW = 6;
    localparam int PW = 96;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          start;
    logic [LW-1:0] len;
    logic          vin;
    logic          rdy;
    logic [PW-1:0] din;
    logic [VW-1:0] sin;
    logic          rin;
    logic          vout;
    logic [DW-1:0] dout;
    logic [15:0]   sout;
    logic          busy;
    logic          done;
    logic [LW-1:0] cnt;

    sfm_out_packer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clear_i(clear),
        .start_i(start),
        .len_i  (len),
        .valid_i(vin),
        .ready_o(rdy),
        .data_i (din),
        .strb_i (sin),
        .valid_o(vout),
        .ready_i(rin),
        .data_o (dout),
        .strb_o (sout),
        .busy_o (busy),
        .done_o (done),
        .cnt_o  (cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(logic [PW-1:0] d, logic [VW-1:0] s);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < VW; i++) begin
            if (s[i]) r[16*i +: 16] = d[16*i +: 16];
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_strb(logic [VW-1:0] s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < VW; i++) begin
            r[2*i +: 2] = {2{s[i]}};
        end
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0] d;
        logic [15:0]   s;
    } beat_t;

    beat_t sb[$];

    int          cyc = 0;
    int          n_out;
    int          n_done;
    int          last_pop_cyc;
    int          done_cyc;
    logic [15:0] first_strb;
    bit          have_first;
    bit          prev_stall;
    logic [DW-1:0] prev_d;

    // monitor/scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (vout && rin) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow act=%0h exp=none", dout);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", dout, e.d);
                    chk("sb_strb", {112'd0, sout}, {112'd0, e.s});
                end
                n_out++;
                last_pop_cyc = cyc;
                if (!have_first) first_strb = sout;
                have_first = 1'b1;
            end
            if (vout && !rin && prev_stall) chk("stall_hold", dout, prev_d);
            prev_stall = vout && !rin;
            prev_d     = dout;
            if (vin && rdy) sb.push_back('{exp_data(din, sin), exp_strb(sin)});
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    typedef struct {
        int          n;
        logic [5:0]  s;
        bit          ones;
        int          mode;
        logic [15:0] exp_s;
    } vec_t;

    task automatic run_job(input int n, input logic [5:0] s, input bit ones,
                           input int mode, input logic [15:0] exp_s);
        int  idx;
        int  t;
        bit  w;
        @(posedge clk); #1;
        n_out = 0; n_done = 0; have_first = 1'b0;
        start = 1'b1; len = LW'(n); vin = 1'b0;
        rin = (mode != 2);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; t = 0;
        while (idx < n && t < 2000) begin
            vin = 1'b1;
            din = ones ? '1 : {$urandom, $urandom, $urandom};
            sin = s;
            case (mode)
                0: rin = 1'b1;
                1: rin = 1'($urandom_range(0, 1));
                default: rin = (t >= 5);
            endcase
            start = (mode == 1 && t == 1);
            len   = start ? LW'(1) : LW'(n);
            if (mode == 2 && t == 5) begin
                chk("stall_ready_o", {127'd0, rdy}, 128'd0);
                chk("stall_accepts", DW'(idx), 128'd2);
            end
            w = rdy;
            @(posedge clk); #1;
            t++;
            if (w) idx++;
        end
        start = 1'b0;
        vin = 1'b0;
        rin = 1'b1;
        t = 0;
        while (n_done == 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_seen", DW'(n_done > 0), 128'd1);
        @(posedge clk); #1;
        chk("done_once", DW'(n_done), 128'd1);
        chk("done_gap", DW'(done_cyc - last_pop_cyc), 128'd1);
        chk("beats_out", DW'(n_out), DW'(n));
        chk("cnt_final", DW'(cnt), DW'(n));
        chk("busy_idle", {127'd0, busy}, 128'd0);
        chk("sb_empty", DW'(sb.size()), 128'd0);
        chk("first_strb", {112'd0, first_strb}, {112'd0, exp_s});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    vec_t tbl[5];

    initial begin
        int t;
        tbl[0] = '{4, 6'b111111, 1'b0, 0, 16'h0FFF};
        tbl[1] = '{3, 6'b000111, 1'b1, 0, 16'h003F};
        tbl[2] = '{5, 6'b101010, 1'b0, 1, 16'h0CCC};
        tbl[3] = '{3, 6'b111111, 1'b0, 2, 16'h0FFF};
        tbl[4] = '{7, 6'b000001, 1'b1, 1, 16'h0003};

        rst_n = 1'b0; clear = 1'b0; start = 1'b0; len = '0;
        vin = 1'b0; din = '0; sin = '0; rin = 1'b1;
        n_out = 0; n_done = 0; have_first = 1'b0;
        #2;
        chk("rst_ready", {127'd0, rdy}, 128'd0);
        chk("rst_valid", {127'd0, vout}, 128'd0);
        chk("rst_data", dout, 128'd0);
        chk("rst_strb", {112'd0, sout}, 128'd0);
        chk("rst_busy_done", {126'd0, busy, done}, 128'd0);
        chk("rst_cnt", DW'(cnt), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].n, tbl[i].s, tbl[i].ones, tbl[i].mode, tbl[i].exp_s);
        end

        // zero-length job
        n_done = 0;
        @(posedge clk); #1;
        start = 1'b1; len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_busy", {127'd0, busy}, 128'd0);
        chk("len0_done", {127'd0, done}, 128'd1);
        chk("len0_cnt", DW'(cnt), 128'd0);
        @(posedge clk); #1;
        chk("len0_done_low", {127'd0, done}, 128'd0);
        chk("len0_valid", {127'd0, vout}, 128'd0);
        chk("len0_pulses", DW'(n_done), 128'd1);

        // clear in RUN with two beats buffered
        @(posedge clk); #1;
        start = 1'b1; len = LW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        sin = 6'b111111;
        for (t = 0; t < 5; t++) begin
            vin = 1'b1;
            din = {$urandom, $urandom, $urandom};
            rin = (t < 3);
            @(posedge clk); #1;
        end
        chk("pre_clr_cnt", DW'(cnt), 128'd2);
        chk("pre_clr_full", {126'd0, rdy, vout}, 128'd1);
        chk("pre_clr_sb", DW'(sb.size()), 128'd2);
        n_done = 0;
        vin = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        sb.delete();
        chk("clr_valid", {127'd0, vout}, 128'd0);
        chk("clr_cnt", DW'(cnt), 128'd0);
        chk("clr_idle", {126'd0, busy, rdy}, 128'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("clr_no_done", DW'(n_done), 128'd0);
        rin = 1'b1;

        // reset pulse mid-DRAIN
        @(posedge clk); #1;
        start = 1'b1; len = LW'(2); rin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        vin = 1'b1; din = '1; sin = 6'b111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vin = 1'b0;
        chk("drain_state", {125'd0, busy, rdy, vout}, 128'd5);
        n_done = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_ready", {126'd0, vout, rdy}, 128'd0);
        chk("arst_data", dout, 128'd0);
        chk("arst_strb", {112'd0, sout}, 128'd0);
        chk("arst_flags", {126'd0, busy, done}, 128'd0);
        chk("arst_cnt", DW'(cnt), 128'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rin = 1'b1;
        chk("arst_no_done", DW'(n_done), 128'd0);
        run_job(2, 6'b111111, 1'b0, 0, 16'h0FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
